mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port flush  input  1  synchronous abort of an operation in progress.
REQ-007 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port hi  output  WIDTH  product upper half / remainder.
REQ-010 SHALL have port lo  output  WIDTH  product lower half / quotient.
REQ-011 SHALL have port busy  output  1  high from the accepting edge until the result is written.
REQ-012 SHALL have port done  output  1  one-cycle pulse; hi/lo are valid and new in that cycle.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE.
REQ-014 In IDLE with start=1 and flush=0, SHALL capture a, b and op, load operand magnitudes, and enter CALC.
REQ-015 SHALL ignore later changes to a, b and op until the next accepted start.
REQ-016 SHALL take exactly WIDTH cycles in CALC, one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 SHALL spend one cycle in FIX applying sign correction, writing hi/lo and returning to IDLE.
REQ-018 SHALL assert done for exactly one cycle, WIDTH+2 edges after the edge that sampled start; busy=0 and hi/lo valid in that cycle.
REQ-019 Unsigned ops SHALL treat a and b as unsigned; MULT and DIV SHALL treat them as two's complement.
REQ-020 Multiply SHALL give {hi,lo} = full 2*WIDTH-bit product; signed product negated iff sign(a) XOR sign(b).
REQ-021 Divide SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of a.
REQ-022 Divide by zero SHALL give lo = all ones and hi = a, for both DIVU and DIV.
REQ-023 DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no trap.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL accept start in a cycle where done=1 (back-to-back operations); the next done follows WIDTH+2 edges later.
REQ-026 flush=1 in CALC or FIX SHALL return the FSM to IDLE on the next edge, with no done and hi/lo unchanged.
REQ-027 flush=1 with start=1 in IDLE: flush wins and start is ignored.
REQ-028 hi/lo SHALL hold the last completed result until the next FIX write.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0 and clear internal datapath registers, including in mid-operation.
REQ-030 start SHALL first be honoured on the first rising edge after reset deasserts.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encoding constants and the FSM state typedef.
REQ-032 Sub-module mdu_addsub (WIDTH+1-bit add/subtract with carry-out) SHALL be the single shared datapath adder for shift-add, shift-subtract and negation.

Verification
REQ-033 MULTU a=20, b=30 -> done at edge 34 after start, hi=0, lo=600.
REQ-034 MULT a=-24, b=311 -> hi=0xFFFFFFFF, lo=0xFFFFE2D8; MULTU with the same bits -> hi=0x00000136, lo=0xFFFFE2D8.
REQ-035 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-036 start pulsed again at cycle 5 of an op -> ignored, single done; start held high on the done cycle -> second result 34 edges later.
REQ-037 flush at CALC cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior result; reset low mid-CALC -> all outputs 0 at once.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM state type and op decode helpers for mult_div_unit
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// rtl/mdu_addsub.sv - shared add/subtract with carry-out used by every datapath step
module mdu_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_full;

    assign w_full = {1'b0, i_x} + {1'b0, i_y ^ {W{i_sub}}} + {{W{1'b0}}, i_sub};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit, signed and unsigned
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       r_state, w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc, r_sh, r_quo, r_nlo, r_b, r_hi, r_lo;
    logic             r_b_neg, r_neg_q, r_neg_r, r_seen, r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_x, w_y, w_sum, w_mstep;
    logic             w_sub, w_cout, w_accept, w_last, w_is_div, w_a_neg;
    logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_is_div = op_is_div(r_op);
    assign w_a_neg  = op_is_signed(op) && a[WIDTH-1];
    assign w_mstep  = r_sh[0] ? w_sum : {1'b0, r_acc};

    mdu_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_sub  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_CALC;
            ST_CALC: if (flush) w_next = ST_IDLE; else if (w_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // b stays raw with a sign-extension bit; add/subtract direction flips so |b| is used.
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_sub = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_y   = {w_a_neg, a};
                w_sub = 1'b1;
            end
            ST_CALC: begin
                w_y = {r_b_neg, r_b};
                if (w_is_div) begin
                    w_x   = {r_acc, r_sh[WIDTH-1]};
                    w_sub = !r_b_neg;
                end else begin
                    w_x   = {1'b0, r_acc};
                    w_sub = r_b_neg;
                end
            end
            ST_FIX: begin
                w_y   = {1'b0, r_acc};
                w_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Low halves were negated bit-serially during CALC; only hi needs the adder here.
    always_comb begin
        if (w_is_div) begin
            w_fix_hi = r_neg_r ? w_sum[WIDTH-1:0] : r_acc;
            w_fix_lo = r_neg_q ? r_nlo : r_quo;
        end else begin
            w_fix_hi = !r_neg_q ? r_acc : (r_seen ? ~r_acc : w_sum[WIDTH-1:0]);
            w_fix_lo = r_neg_q ? r_nlo : r_sh;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= '0;
            r_acc   <= '0;
            r_sh    <= '0;
            r_quo   <= '0;
            r_nlo   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b_neg <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_seen  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_op    <= op;
                    r_b     <= b;
                    r_b_neg <= op_is_signed(op) && b[WIDTH-1];
                    r_neg_q <= op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                    r_neg_r <= w_a_neg;
                    r_acc   <= '0;
                    r_sh    <= w_a_neg ? w_sum[WIDTH-1:0] : a;
                    r_quo   <= '0;
                    r_nlo   <= '0;
                    r_seen  <= 1'b0;
                    r_cnt   <= '0;
                end
                ST_CALC: if (!flush) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_div) begin
                        r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                        r_quo <= {r_quo[WIDTH-2:0], w_cout};
                        r_nlo <= w_cout ? {~r_quo[WIDTH-2:0], 1'b1} : {r_nlo[WIDTH-2:0], 1'b0};
                        r_acc <= w_cout ? w_sum[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_sh[WIDTH-1]};
                    end else begin
                        r_acc  <= w_mstep[WIDTH:1];
                        r_sh   <= {w_mstep[0], r_sh[WIDTH-1:1]};
                        r_nlo  <= {w_mstep[0] ^ r_seen, r_nlo[WIDTH-1:1]};
                        r_seen <= r_seen | w_mstep[0];
                    end
                end
                ST_FIX: if (!flush) begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = ~o; a = ~x; b = ~y;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int e = 0; e < 80; e++) begin
            if (done) begin
                lat = e + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_multu;
        int lat;
        launch(2'b00, 32'd20, 32'd30);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL multu_busy got=%b exp=1", busy); end
        wait_done(lat);
        checks++; if (lat != 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_done got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL multu_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd600) begin failures++; $display("FAIL multu_lo got=%h exp=258", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_vectors;
        vec_t v [13];
        int lat;
        v[0]  = '{2'b01, 32'hFFFFFFE8, 32'h00000137, 32'hFFFFFFFF, 32'hFFFFE2D8};
        v[1]  = '{2'b00, 32'hFFFFFFE8, 32'h00000137, 32'h00000136, 32'hFFFFE2D8};
        v[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[3]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[4]  = '{2'b01, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        v[5]  = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        v[6]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[7]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[8]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        v[9]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[10] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        v[11] = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        v[12] = '{2'b10, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
        for (int i = 0; i < 13; i++) begin
            launch(v[i].op, v[i].a, v[i].b);
            wait_done(lat);
            checks++; if (lat != 34) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (hi !== v[i].hi) begin failures++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, v[i].hi); end
            checks++; if (lo !== v[i].lo) begin failures++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, v[i].lo); end
        end
    endtask

    task automatic test_ignore_start;
        int n_done = 0;
        int first = -1;
        launch(2'b00, 32'd3, 32'd5);
        for (int e = 0; e < 60; e++) begin
            if (e == 5) begin
                start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first < 0) first = e + 1;
                checks++; if (lo !== 32'd15) begin failures++; $display("FAIL ignore_lo got=%h exp=f", lo); end
            end
            @(negedge clk);
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        checks++; if (first != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", first); end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(2'b10, 32'd100, 32'd7);
        wait_done(lat);
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_first_lo got=%h exp=e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_first_hi got=%h exp=2", hi); end
        @(negedge clk);
        start = 1'b0; a = 32'd0; b = 32'd0;
        wait_done(lat);
        checks++; if (lat != 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL b2b_second_lo got=%h exp=2a", lo); end
    endtask

    task automatic test_flush;
        int lat;
        int n_done;
        launch(2'b00, 32'd9, 32'd9);
        wait_done(lat);
        checks++; if (lo !== 32'd81) begin failures++; $display("FAIL flush_prior_lo got=%h exp=51", lo); end
        for (int pass = 0; pass < 2; pass++) begin
            n_done = 0;
            launch(2'b10, 32'd50, 32'd3);
            for (int e = 0; e < 45; e++) begin
                flush = ((pass == 0) && (e == 9)) || ((pass == 1) && (e == 32));
                if (done) n_done++;
                @(negedge clk);
                if (e == 9 && pass == 0) begin
                    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_calc_busy got=%b exp=0", busy); end
                end
                if (e == 32 && pass == 1) begin
                    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_fix_busy got=%b exp=0", busy); end
                end
            end
            flush = 1'b0;
            checks++; if (n_done != 0) begin failures++; $display("FAIL flush%0d_done got=%0d exp=0", pass, n_done); end
            checks++; if (lo !== 32'd81) begin failures++; $display("FAIL flush%0d_lo got=%h exp=51", pass, lo); end
            checks++; if (hi !== 32'd0) begin failures++; $display("FAIL flush%0d_hi got=%h exp=0", pass, hi); end
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat;
        launch(2'b00, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL midreset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        @(negedge clk);
        reset = 1'b1;
        launch(2'b00, 32'd2, 32'd3);
        wait_done(lat);
        checks++; if (lat != 34) begin failures++; $display("FAIL post_reset_latency got=%0d exp=34", lat); end
        checks++; if (lo !== 32'd6) begin failures++; $display("FAIL post_reset_lo got=%h exp=6", lo); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        #1;
        test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_multu;
        test_vectors;
        test_ignore_start;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
